// File: rtl/lsu_axi_master.sv
// LSU bus front-end: one load/store at a time -> single AXI4-Lite read/write; 1-cycle issue latency.
// Backpressure: stalls indefinitely on any AXI channel or on resp_ready; req_ready low while busy.
module lsu_axi_master #(
  parameter int ADDR_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  logic [2:0]        state;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        req_off;
  logic              misaligned;
  logic              bad_req;
  logic [ADDR_W-1:0] addr_al;
  logic [31:0]       lane;
  logic [31:0]       load_ext;
  logic [3:0]        strb_nxt;
  logic              aw_done;
  logic              w_done;

  assign req_off = req_addr[1:0];
  assign addr_al = {req_addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    misaligned = 1'b0;
    if (CHECK_ALIGN)
      misaligned = ((req_size == 2'd1) && req_off[0]) ||
                   ((req_size == 2'd2) && (req_off != 2'b00));
    bad_req = misaligned || (req_size == 2'd3);
  end

  always_comb begin
    case (req_size)
      2'd0:    strb_nxt = 4'b0001 << req_off;
      2'd1:    strb_nxt = 4'b0011 << req_off;
      default: strb_nxt = 4'b1111;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend according to the latched size.
  always_comb begin
    lane = rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    load_ext = uns_q ? {24'h0, lane[7:0]}   : {{24{lane[7]}}, lane[7:0]};
      2'd1:    load_ext = uns_q ? {16'h0, lane[15:0]}  : {{16{lane[15]}}, lane[15:0]};
      default: load_ext = rdata;
    endcase
  end

  // A channel is done once its valid has dropped or is handshaking this cycle.
  assign aw_done = !awvalid || awready;
  assign w_done  = !wvalid  || wready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      araddr     <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awaddr     <= '0;
      awvalid    <= 1'b0;
      wdata      <= 32'h0;
      wstrb      <= 4'h0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            off_q     <= req_off;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            if (bad_req) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (!req_wen) begin
              state   <= S_AR;
              arvalid <= 1'b1;
              araddr  <= addr_al;
            end else begin
              state   <= S_WR;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              awaddr  <= addr_al;
              wdata   <= req_wdata << {req_off, 3'b000};
              wstrb   <= strb_nxt;
            end
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_R;
          end
        end
        S_R: begin
          if (rvalid) begin
            rready     <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= load_ext;
            resp_err   <= (rresp != 2'b00);
            state      <= S_RESP;
          end
        end
        S_WR: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            bready <= 1'b1;
            state  <= S_B;
          end
        end
        S_B: begin
          if (bvalid) begin
            bready     <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= 32'h0;
            resp_err   <= (bresp != 2'b00);
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master with a reactive AXI4-Lite slave whose per-channel delays are programmable.
module tb_lsu_axi_master;
  logic        clk, rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  int n_checks = 0;
  int n_errors = 0;

  // slave configuration and observation
  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] r_val = 32'h0;
  logic [1:0]  r_resp = 2'b00, b_resp = 2'b00;
  int          ar_hs_cnt = 0, arvalid_cyc = 0, bready_early = 0;
  logic [31:0] cap_araddr = 32'h0, cap_awaddr = 32'h0, cap_wdata = 32'h0;
  logic [3:0]  cap_wstrb = 4'h0;

  // slave internal state
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic r_pend, b_pend, aw_got, w_got;
  int   ar_c, aw_c, w_c, r_c, b_c;

  lsu_axi_master #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave: handshakes sampled at negedge, responses driven just after posedge.
  initial begin
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
    forever begin
      @(negedge clk);
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      if (rst) begin
        if (arvalid) arvalid_cyc++;
        if (ar_hs) begin ar_hs_cnt++; cap_araddr = araddr; end
        if (aw_hs) cap_awaddr = awaddr;
        if (w_hs) begin cap_wdata = wdata; cap_wstrb = wstrb; end
        if (bready && (awvalid || wvalid)) bready_early++;
      end
      @(posedge clk); #1;
      if (!rst) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
      end else begin
        if (ar_hs) begin r_pend = 1; r_c = 0; end
        if (aw_hs) aw_got = 1;
        if (w_hs)  w_got = 1;
        if (aw_got && w_got) begin b_pend = 1; b_c = 0; aw_got = 0; w_got = 0; end
        if (r_hs) rvalid = 0;
        if (r_pend) begin
          if (r_c >= r_dly) begin rvalid = 1; rdata = r_val; rresp = r_resp; r_pend = 0; end
          else r_c++;
        end
        if (b_hs) bvalid = 0;
        if (b_pend) begin
          if (b_c >= b_dly) begin bvalid = 1; bresp = b_resp; b_pend = 0; end
          else b_c++;
        end
        if (!arvalid) ar_c = 0;
        arready = arvalid && (ar_c >= ar_dly);
        if (arvalid && !arready) ar_c++;
        if (!awvalid) aw_c = 0;
        awready = awvalid && (aw_c >= aw_dly);
        if (awvalid && !awready) aw_c++;
        if (!wvalid) w_c = 0;
        wready = wvalid && (w_c >= w_dly);
        if (wvalid && !wready) w_c++;
      end
    end
  end

  // Issue one request (entered just after a posedge), collect the response, optionally stall resp_ready.
  task automatic do_req(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic uns, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    int n = 0;
    req_valid = 1; req_wen = wen; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = uns;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("req_ready_wait", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 0;
    lat = 1;
    while (!resp_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    check("resp_valid_wait", {31'h0, resp_valid}, 32'h1);
    rd = resp_rdata;
    er = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'h0, resp_valid}, 32'h1);
      check("hold_err", {31'h0, resp_err}, {31'h0, er});
      check("hold_rdata", resp_rdata, rd);
      check("hold_req_ready", {31'h0, req_ready}, 32'h0);
    end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    check("req_ready_after_resp", {31'h0, req_ready}, 32'h1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, base;

  initial begin
    req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_unsigned = 0;
    resp_ready = 0;
    rst = 1;
    #1 rst = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_valids", {26'h0, arvalid, rready, awvalid, wvalid, bready, resp_valid}, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_addrs", araddr | awaddr | wdata | resp_rdata, 32'h0);
    check("rst_wstrb", {28'h0, wstrb}, 32'h0);
    rst = 1;
    @(posedge clk); #1;

    // zero-wait word load: acceptance -> resp_valid in 3 cycles
    r_val = 32'h12345678;
    do_req(1'b0, 32'h80000010, 32'h0, 2'd2, 1'b0, 0, rd, er, lat);
    check("ld0_rdata", rd, 32'h12345678);
    check("ld0_err", {31'h0, er}, 32'h0);
    check("ld0_lat", lat, 3);

    // word load with slow read data
    r_dly = 3; r_val = 32'hDEADBEEF; base = ar_hs_cnt;
    do_req(1'b0, 32'h80000004, 32'h0, 2'd2, 1'b0, 0, rd, er, lat);
    check("ld1_ar_count", ar_hs_cnt - base, 1);
    check("ld1_araddr", cap_araddr, 32'h80000004);
    check("ld1_rdata", rd, 32'hDEADBEEF);
    check("ld1_err", {31'h0, er}, 32'h0);
    r_dly = 0;

    // lane selection and extension
    r_val = 32'h80FF1234;
    do_req(1'b0, 32'h80000003, 32'h0, 2'd0, 1'b0, 0, rd, er, lat);
    check("lb_off3_signed", rd, 32'hFFFFFF80);
    check("lb_off3_araddr", cap_araddr, 32'h80000000);
    do_req(1'b0, 32'h80000003, 32'h0, 2'd0, 1'b1, 0, rd, er, lat);
    check("lbu_off3", rd, 32'h00000080);
    do_req(1'b0, 32'h80000002, 32'h0, 2'd1, 1'b0, 0, rd, er, lat);
    check("lh_off2_signed", rd, 32'hFFFF80FF);
    do_req(1'b0, 32'h80000000, 32'h0, 2'd1, 1'b1, 0, rd, er, lat);
    check("lhu_off0", rd, 32'h00001234);
    do_req(1'b0, 32'h80000001, 32'h0, 2'd0, 1'b0, 0, rd, er, lat);
    check("lb_off1_signed", rd, 32'h00000012);

    // half store, AW accepted 2 cycles before W
    aw_dly = 1; w_dly = 3; base = bready_early;
    do_req(1'b1, 32'h80000002, 32'h0000ABCD, 2'd1, 1'b0, 0, rd, er, lat);
    check("sh_awaddr", cap_awaddr, 32'h80000000);
    check("sh_wdata", cap_wdata, 32'hABCD0000);
    check("sh_wstrb", {28'h0, cap_wstrb}, 32'hC);
    check("sh_err", {31'h0, er}, 32'h0);
    check("sh_rdata", rd, 32'h0);
    check("sh_bready_early", bready_early - base, 0);
    aw_dly = 0; w_dly = 0;

    // misaligned word load: immediate error, no AR
    base = arvalid_cyc;
    do_req(1'b0, 32'h80000001, 32'h0, 2'd2, 1'b0, 0, rd, er, lat);
    check("mis_err", {31'h0, er}, 32'h1);
    check("mis_lat", lat, 1);
    check("mis_rdata", rd, 32'h0);
    check("mis_no_ar", arvalid_cyc - base, 0);

    // reserved size
    do_req(1'b0, 32'h80000000, 32'h0, 2'd3, 1'b0, 0, rd, er, lat);
    check("size3_err", {31'h0, er}, 32'h1);

    // byte store with SLVERR and a stalled response consumer
    b_resp = 2'b10;
    do_req(1'b1, 32'h80000001, 32'h0000005A, 2'd0, 1'b0, 5, rd, er, lat);
    check("sb_err", {31'h0, er}, 32'h1);
    check("sb_wdata", cap_wdata, 32'h00005A00);
    check("sb_wstrb", {28'h0, cap_wstrb}, 32'h2);
    b_resp = 2'b00;

    // read error response
    r_resp = 2'b10; r_val = 32'h0;
    do_req(1'b0, 32'h80000008, 32'h0, 2'd2, 1'b0, 0, rd, er, lat);
    check("rerr_err", {31'h0, er}, 32'h1);
    r_resp = 2'b00;

    // reset while waiting for read data
    r_dly = 40;
    req_valid = 1; req_wen = 0; req_addr = 32'h80000020; req_size = 2'd2; req_unsigned = 0;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 0;
    while (!rready && lat < 20) begin @(posedge clk); #1; lat++; end
    check("rst_mid_in_r", {31'h0, rready}, 32'h1);
    rst = 0;
    #1;
    check("rst_mid_valids", {26'h0, arvalid, rready, awvalid, wvalid, bready, resp_valid}, 32'h0);
    check("rst_mid_req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1; r_dly = 0;
    @(posedge clk); #1;
    check("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
    r_val = 32'hCAFEF00D;
    do_req(1'b0, 32'h80000024, 32'h0, 2'd2, 1'b0, 0, rd, er, lat);
    check("post_rst_rdata", rd, 32'hCAFEF00D);
    check("post_rst_err", {31'h0, er}, 32'h0);
    check("post_rst_lat", lat, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
